// File: rtl/pe_acc_tree_pkg.sv
// Shared PE definitions: product vector geometry and the saturating accumulate helper.
package pe_acc_tree_pkg;

  localparam int PE_LANES  = 32;
  localparam int PE_PROD_W = 32;
  localparam int PE_VEC_W  = PE_LANES * PE_PROD_W;

  // Working width of sat_add; callers sign-extend into it, so any acc_w up to 63 is exact.
  localparam int SAT_W = 64;

  typedef struct packed {
    logic [SAT_W-1:0] sum;
    logic             sat;
  } sat_res_t;

  function automatic sat_res_t sat_add(input logic signed [SAT_W-1:0] a,
                                       input logic signed [SAT_W-1:0] b,
                                       input int unsigned             acc_w);
    logic signed [SAT_W-1:0] raw;
    logic signed [SAT_W-1:0] max_v;
    logic signed [SAT_W-1:0] min_v;
    sat_res_t                res;
    raw     = a + b;
    max_v   = (64'sd1 <<< (acc_w - 1)) - 64'sd1;
    min_v   = -max_v - 64'sd1;
    res.sum = raw;
    res.sat = 1'b0;
    if (raw > max_v) begin
      res.sum = max_v;
      res.sat = 1'b1;
    end else if (raw < min_v) begin
      res.sum = min_v;
      res.sat = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/pe_add4.sv
// Combinational 4-input signed adder; output is two bits wider so it never overflows.
module pe_add4 #(
  parameter int IN_W = 32
) (
  input  logic [IN_W-1:0] a,
  input  logic [IN_W-1:0] b,
  input  logic [IN_W-1:0] c,
  input  logic [IN_W-1:0] d,
  output logic [IN_W+1:0] sum
);

  assign sum = {{2{a[IN_W-1]}}, a} + {{2{b[IN_W-1]}}, b}
             + {{2{c[IN_W-1]}}, c} + {{2{d[IN_W-1]}}, d};

endmodule

// File: rtl/pe_acc_tree.sv
// Registered 32-lane reduction tree (S1..S3) followed by a saturating dot-product
// accumulator (S4) that emits one result per chunk sequence closed by mult_last.
module pe_acc_tree
  import pe_acc_tree_pkg::*;
#(
  parameter int ACC_W = 48,
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PE_VEC_W-1:0] mult_result,
  input  logic                mult_valid,
  input  logic                mult_last,
  output logic [ACC_W-1:0]    acc_result,
  output logic                acc_valid,
  output logic                acc_ovf,
  output logic [CNT_W-1:0]    acc_chunks
);

  // Handshake: no backpressure; a chunk is taken whenever mult_valid is high, and
  // acc_valid is a one-cycle strobe that the consumer must sample when it fires.

  logic [33:0] s1_sum [8];
  logic [33:0] s1_d   [8];
  logic [33:0] s1_q   [8];
  logic [35:0] s2_sum [2];
  logic [35:0] s2_d   [2];
  logic [35:0] s2_q   [2];
  logic [36:0] s3_d;
  logic [36:0] s3_q;

  logic s1_valid_d, s1_valid_q, s1_last_d, s1_last_q;
  logic s2_valid_d, s2_valid_q, s2_last_d, s2_last_q;
  logic s3_valid_d, s3_valid_q, s3_last_d, s3_last_q;

  logic [ACC_W-1:0] acc_d, acc_q;
  logic             sticky_d, sticky_q;
  logic [CNT_W-1:0] cnt_d, cnt_q, cnt_inc;
  logic [ACC_W-1:0] res_d, res_q;
  logic             ovf_d, ovf_q;
  logic [CNT_W-1:0] chunks_d, chunks_q;
  logic             valid_d, valid_q;

  sat_res_t               sat_r;
  logic [ACC_W-1:0]       acc_sum;
  logic [SAT_W-ACC_W-1:0] unused_sum_hi;

  for (genvar g = 0; g < 8; g++) begin : g_s1
    pe_add4 #(.IN_W(PE_PROD_W)) u_add (
      .a   (mult_result[(4*g+0)*PE_PROD_W +: PE_PROD_W]),
      .b   (mult_result[(4*g+1)*PE_PROD_W +: PE_PROD_W]),
      .c   (mult_result[(4*g+2)*PE_PROD_W +: PE_PROD_W]),
      .d   (mult_result[(4*g+3)*PE_PROD_W +: PE_PROD_W]),
      .sum (s1_sum[g])
    );
  end

  for (genvar g = 0; g < 2; g++) begin : g_s2
    pe_add4 #(.IN_W(34)) u_add (
      .a   (s1_q[4*g+0]),
      .b   (s1_q[4*g+1]),
      .c   (s1_q[4*g+2]),
      .d   (s1_q[4*g+3]),
      .sum (s2_sum[g])
    );
  end

  always_comb begin
    for (int i = 0; i < 8; i++) s1_d[i] = s1_sum[i];
    for (int i = 0; i < 2; i++) s2_d[i] = s2_sum[i];
    s3_d = {s2_q[0][35], s2_q[0]} + {s2_q[1][35], s2_q[1]};

    s1_valid_d = mult_valid;
    s1_last_d  = mult_valid & mult_last;
    s2_valid_d = s1_valid_q;
    s2_last_d  = s1_last_q;
    s3_valid_d = s2_valid_q;
    s3_last_d  = s2_last_q;
  end

  always_comb begin
    sat_r = sat_add({{(SAT_W-ACC_W){acc_q[ACC_W-1]}}, acc_q},
                    {{(SAT_W-37){s3_q[36]}}, s3_q}, ACC_W);
    acc_sum       = sat_r.sum[ACC_W-1:0];
    unused_sum_hi = sat_r.sum[SAT_W-1:ACC_W];
    cnt_inc       = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

    acc_d    = acc_q;
    sticky_d = sticky_q;
    cnt_d    = cnt_q;
    res_d    = res_q;
    ovf_d    = ovf_q;
    chunks_d = chunks_q;
    valid_d  = 1'b0;
    if (s3_valid_q) begin
      if (s3_last_q) begin
        res_d    = acc_sum;
        ovf_d    = sticky_q | sat_r.sat;
        chunks_d = cnt_inc;
        valid_d  = 1'b1;
        // Clear so the very next chunk opens a fresh dot product.
        acc_d    = '0;
        sticky_d = 1'b0;
        cnt_d    = '0;
      end else begin
        acc_d    = acc_sum;
        sticky_d = sticky_q | sat_r.sat;
        cnt_d    = cnt_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_last_q  <= 1'b0;
      s3_valid_q <= 1'b0;
      s3_last_q  <= 1'b0;
      acc_q      <= '0;
      sticky_q   <= 1'b0;
      cnt_q      <= '0;
      res_q      <= '0;
      ovf_q      <= 1'b0;
      chunks_q   <= '0;
      valid_q    <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_last_q  <= s1_last_d;
      s2_valid_q <= s2_valid_d;
      s2_last_q  <= s2_last_d;
      s3_valid_q <= s3_valid_d;
      s3_last_q  <= s3_last_d;
      acc_q      <= acc_d;
      sticky_q   <= sticky_d;
      cnt_q      <= cnt_d;
      res_q      <= res_d;
      ovf_q      <= ovf_d;
      chunks_q   <= chunks_d;
      valid_q    <= valid_d;
    end
  end

  // Tree datapath is qualified by the valid bits, so it needs no reset.
  always_ff @(posedge clk) begin
    s1_q <= s1_d;
    s2_q <= s2_d;
    s3_q <= s3_d;
  end

  assign acc_result = res_q;
  assign acc_valid  = valid_q;
  assign acc_ovf    = ovf_q;
  assign acc_chunks = chunks_q;

endmodule

// File: tb/tb_pe_acc_tree.sv
// Directed bench for pe_acc_tree: a 48-bit and a 38-bit accumulator share one stimulus stream.
module tb_pe_acc_tree;

  localparam int EXP_W = 16 + 16 + 1 + 48;

  logic          clk;
  logic          rst;
  logic [1023:0] mult_result;
  logic          mult_valid;
  logic          mult_last;

  logic [47:0] acc_result;
  logic        acc_valid;
  logic        acc_ovf;
  logic [15:0] acc_chunks;
  logic [37:0] acc_result_s;
  logic        acc_valid_s;
  logic        acc_ovf_s;
  logic [15:0] acc_chunks_s;

  pe_acc_tree #(.ACC_W(48), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .mult_result(mult_result), .mult_valid(mult_valid),
    .mult_last(mult_last), .acc_result(acc_result), .acc_valid(acc_valid),
    .acc_ovf(acc_ovf), .acc_chunks(acc_chunks)
  );

  pe_acc_tree #(.ACC_W(38), .CNT_W(16)) dut_s (
    .clk(clk), .rst(rst), .mult_result(mult_result), .mult_valid(mult_valid),
    .mult_last(mult_last), .acc_result(acc_result_s), .acc_valid(acc_valid_s),
    .acc_ovf(acc_ovf_s), .acc_chunks(acc_chunks_s)
  );

  // Clock / reset and cycle counter
  int cyc;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc++;

  int n_checks = 0;
  int n_fail   = 0;
  int send_cyc = 0;

  logic [EXP_W-1:0] exp_q[$];
  logic [EXP_W-1:0] exp_s_q[$];

  function automatic logic [EXP_W-1:0] pack(input int c, input logic [15:0] ch,
                                            input logic ov, input logic [47:0] r);
    logic [31:0] cv;
    cv = c;
    return {cv[15:0], ch, ov, r};
  endfunction

  function automatic logic [1023:0] all_lanes(input logic [31:0] x);
    logic [1023:0] v;
    for (int i = 0; i < 32; i++) v[32*i +: 32] = x;
    return v;
  endfunction

  function automatic logic [1023:0] lane_index();
    logic [1023:0] v;
    for (int i = 0; i < 32; i++) v[32*i +: 32] = i;
    return v;
  endfunction

  // Driver tasks
  task automatic send(input logic [1023:0] v, input logic last);
    @(posedge clk); #1;
    mult_result = v;
    mult_valid  = 1'b1;
    mult_last   = last;
    send_cyc    = cyc;
  endtask

  task automatic idle(input int n, input logic junk_last);
    repeat (n) begin
      @(posedge clk); #1;
      mult_valid = 1'b0;
      mult_last  = junk_last;
      for (int i = 0; i < 32; i++) mult_result[32*i +: 32] = $urandom_range(32'hffff_ffff, 0);
    end
  endtask

  task automatic expect_pulse(input logic [47:0] r48, input logic o48,
                              input logic [47:0] r38, input logic o38, input logic [15:0] ch);
    exp_q.push_back(pack(send_cyc + 4, ch, o48, r48));
    exp_s_q.push_back(pack(send_cyc + 4, ch, o38, r38));
  endtask

  task automatic check_held(input string tag, input logic [47:0] r48, input logic [47:0] r38,
                            input logic ov, input logic [15:0] ch);
    logic [65:0] obs;
    logic [65:0] expv;
    @(negedge clk);
    obs  = {acc_valid, acc_ovf, acc_chunks, acc_result};
    expv = {1'b0, ov, ch, r48};
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed %h expected %h", tag, obs, expv);
    end
    obs  = {acc_valid_s, acc_ovf_s, acc_chunks_s, {{10{acc_result_s[37]}}, acc_result_s}};
    expv = {1'b0, ov, ch, r38};
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s_w38 observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Scoreboard: every acc_valid pulse must match the head of its expected queue
  logic [EXP_W-1:0] e48, o48, e38, o38;

  always @(negedge clk) begin
    if (acc_valid === 1'b1) begin
      n_checks++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL pulse48_unexpected observed pulse at cycle %0d expected none", cyc);
      end
      if (exp_q.size() != 0) begin
        e48 = exp_q.pop_front();
        o48 = pack(cyc, acc_chunks, acc_ovf, acc_result);
        n_checks++;
        assert (o48 === e48) else begin
          n_fail++;
          $error("FAIL pulse48 observed %h expected %h", o48, e48);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (acc_valid_s === 1'b1) begin
      n_checks++;
      assert (exp_s_q.size() != 0) else begin
        n_fail++;
        $error("FAIL pulse38_unexpected observed pulse at cycle %0d expected none", cyc);
      end
      if (exp_s_q.size() != 0) begin
        e38 = exp_s_q.pop_front();
        o38 = pack(cyc, acc_chunks_s, acc_ovf_s, {{10{acc_result_s[37]}}, acc_result_s});
        n_checks++;
        assert (o38 === e38) else begin
          n_fail++;
          $error("FAIL pulse38 observed %h expected %h", o38, e38);
        end
      end
    end
  end

  // Directed stimulus
  initial begin
    logic [1023:0] v;
    rst         = 1'b1;
    mult_valid  = 1'b0;
    mult_last   = 1'b0;
    mult_result = '0;
    repeat (3) @(posedge clk);
    check_held("reset_state", 48'd0, 48'd0, 1'b0, 16'd0);
    rst = 1'b0;

    // Single chunk, all lanes 3
    send(all_lanes(32'd3), 1'b1);
    expect_pulse(48'd96, 1'b0, 48'd96, 1'b0, 16'd1);
    idle(6, 1'b0);

    // Three chunks back to back
    v = all_lanes(32'd0);
    v[31:0] = 32'h7fff_ffff;
    send(lane_index(), 1'b0);
    send(all_lanes(32'hffff_ffff), 1'b0);
    send(v, 1'b1);
    expect_pulse(48'd2147484111, 1'b0, 48'd2147484111, 1'b0, 16'd3);
    idle(6, 1'b0);

    // Same three chunks with bubbles; stray last without valid must be ignored
    send(lane_index(), 1'b0);
    idle(2, 1'b1);
    send(all_lanes(32'hffff_ffff), 1'b0);
    idle(2, 1'b1);
    check_held("held_between_pulses", 48'd2147484111, 48'd2147484111, 1'b0, 16'd3);
    send(v, 1'b1);
    expect_pulse(48'd2147484111, 1'b0, 48'd2147484111, 1'b0, 16'd3);
    idle(6, 1'b0);

    // Saturation: five chunks of 32 x -2^31; only the 38-bit accumulator clips
    for (int k = 0; k < 5; k++) send(all_lanes(32'h8000_0000), (k == 4));
    expect_pulse(-48'sd343597383680, 1'b0, -48'sd137438953472, 1'b1, 16'd5);
    send(all_lanes(32'd1), 1'b1);
    expect_pulse(48'd32, 1'b0, 48'd32, 1'b0, 16'd1);
    idle(6, 1'b0);

    // Back-to-back single-chunk products
    for (int k = 1; k <= 8; k++) begin
      send(all_lanes(k), 1'b1);
      expect_pulse(48'(32 * k), 1'b0, 48'(32 * k), 1'b0, 16'd1);
    end
    idle(6, 1'b0);

    // Reset while two non-last chunks are in flight
    send(all_lanes(32'd5), 1'b0);
    send(all_lanes(32'd7), 1'b0);
    idle(1, 1'b0);
    @(posedge clk); #1;
    rst        = 1'b1;
    mult_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    check_held("mid_reset_state", 48'd0, 48'd0, 1'b0, 16'd0);
    send(all_lanes(32'd1), 1'b1);
    expect_pulse(48'd32, 1'b0, 48'd32, 1'b0, 16'd1);
    idle(8, 1'b0);

    n_checks++;
    assert (exp_q.size() == 0) else begin
      n_fail++;
      $error("FAIL missing_pulses48 observed %0d outstanding expected 0", exp_q.size());
    end
    n_checks++;
    assert (exp_s_q.size() == 0) else begin
      n_fail++;
      $error("FAIL missing_pulses38 observed %0d outstanding expected 0", exp_s_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
